ball_engine: RTL and testbench

Parametrised successor to the fixed-geometry Pong ball block. It owns ball position, direction and speed, and resolves wall bounces, paddle hits and misses. It issues single-cycle score pulses and runs a serve state machine. It sits between the paddle controllers (paddle Y inputs) and the scorekeeper/VGA renderer (score pulses, ball position).

---
 rtl/ball_engine.sv | 198 +++++++++++++++++++
 tb/tb_ball_engine.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ball_engine.sv
// Pong ball engine: position, bounces, paddle hits, misses,
// score pulses and the serve/move/scored state machine.
module ball_engine #(
  parameter int SCREEN_W         = 640,
  parameter int SCREEN_H         = 480,
  parameter int BALL_SIZE        = 8,
  parameter int PADDLE_H         = 48,
  parameter int PADDLE_W         = 8,
  parameter int PADDLE_X_LEFT    = 16,
  parameter int PADDLE_X_RIGHT   = 616,
  parameter int TICK_DIV         = 833333,
  parameter int SERVE_DELAY      = 60,
  parameter int SPEED_INIT       = 1,
  parameter int SPEED_MAX        = 4,
  parameter int HITS_PER_SPEEDUP = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  left_paddle_y,
  input  logic [9:0]  right_paddle_y,
  input  logic        pause,
  output logic [10:0] ball_pos_x,
  output logic [10:0] ball_pos_y,
  output logic        score_left,
  output logic        score_right,
  output logic [2:0]  speed,
  output logic [7:0]  hit_count,
  output logic        serving
);

  typedef enum logic [1:0] {SERVE, MOVE, SCORED} state_t;

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] TONE = CW'(1);
  localparam logic [10:0] CX = 11'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [10:0] CY = 11'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [2:0] S_INIT = 3'(SPEED_INIT);
  localparam logic [2:0] S_MAX = 3'(SPEED_MAX);
  localparam logic signed [11:0] BS = 12'(BALL_SIZE);
  localparam logic signed [11:0] SW = 12'(SCREEN_W);
  localparam logic signed [11:0] SH = 12'(SCREEN_H);
  localparam logic signed [11:0] PH = 12'(PADDLE_H);
  localparam logic signed [11:0] LX = 12'(PADDLE_X_LEFT + PADDLE_W);
  localparam logic signed [11:0] RX = 12'(PADDLE_X_RIGHT);
  localparam logic signed [11:0] RXB = 12'(PADDLE_X_RIGHT - BALL_SIZE);
  localparam logic signed [11:0] YB = 12'(SCREEN_H - BALL_SIZE);

  state_t state_q, state_d;
  logic [CW-1:0] tcnt_q, tcnt_d;
  logic [15:0] scnt_q, scnt_d;
  logic [10:0] x_q, x_d, y_q, y_d;
  logic dl_q, dl_d, du_q, du_d;
  logic [2:0] spd_q, spd_d;
  logic [7:0] hc_q, hc_d;
  logic sl_q, sl_d, sr_q, sr_d;

  logic tick;
  logic signed [11:0] xs, ys, sp, nx, ny, lp, rp;
  logic ovl_l, ovl_r, hit_l, hit_r, miss_l, miss_r;
  logic hit, miss, speedup, serve_done;
  logic [7:0] hc_inc;

  assign tick = (tcnt_q == TMAX);
  assign xs = $signed({1'b0, x_q});
  assign ys = $signed({1'b0, y_q});
  assign sp = $signed({9'd0, spd_q});
  assign lp = $signed({2'd0, left_paddle_y});
  assign rp = $signed({2'd0, right_paddle_y});
  assign nx = dl_q ? xs - sp : xs + sp;
  assign ny = du_q ? ys - sp : ys + sp;

  assign ovl_l = (ys + BS > lp) && (ys < lp + PH);
  assign ovl_r = (ys + BS > rp) && (ys < rp + PH);
  assign hit_l = dl_q && (xs >= LX) && (nx <= LX) && ovl_l;
  assign hit_r = !dl_q && (xs + BS <= RX) && (nx + BS >= RX) && ovl_r;
  assign miss_l = dl_q && (nx <= 12'sd0);
  assign miss_r = !dl_q && (nx + BS >= SW);
  assign hit = hit_l || hit_r;
  assign miss = !hit && (miss_l || miss_r);

  assign hc_inc = (hc_q == 8'hff) ? hc_q : hc_q + 8'd1;
  assign speedup =
    (32'(hc_inc) % 32'(HITS_PER_SPEEDUP)) == 32'd0;
  assign serve_done =
    (32'(scnt_q) + 32'd1) >= 32'(SERVE_DELAY);

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    scnt_d  = scnt_q;
    x_d     = x_q;
    y_d     = y_q;
    dl_d    = dl_q;
    du_d    = du_q;
    spd_d   = spd_q;
    hc_d    = hc_q;
    sl_d    = 1'b0;
    sr_d    = 1'b0;
    if (!pause) begin
      tcnt_d = tick ? '0 : tcnt_q + TONE;
      unique case (state_q)
        SERVE: begin
          x_d = CX;
          y_d = CY;
          if (tick) begin
            scnt_d = scnt_q + 16'd1;
            if (serve_done) begin
              state_d = MOVE;
              scnt_d  = '0;
            end
          end
        end
        MOVE: if (tick) begin
          if (hit_l) begin
            x_d  = LX[10:0];
            dl_d = 1'b0;
          end else if (hit_r) begin
            x_d  = RXB[10:0];
            dl_d = 1'b1;
          end else if (miss_l) begin
            sr_d    = 1'b1;
            state_d = SCORED;
          end else if (miss_r) begin
            sl_d    = 1'b1;
            state_d = SCORED;
          end else begin
            x_d = nx[10:0];
          end
          // a miss freezes the ball where it was; centre comes next
          if (!miss) begin
            if (ny <= 12'sd0) begin
              y_d  = '0;
              du_d = 1'b0;
            end else if (ny + BS >= SH) begin
              y_d  = YB[10:0];
              du_d = 1'b1;
            end else begin
              y_d = ny[10:0];
            end
          end
          if (hit) begin
            hc_d = hc_inc;
            if (speedup && spd_q < S_MAX)
              spd_d = spd_q + 3'd1;
          end
        end
        SCORED: begin
          // dir_x is kept: it already points at the conceding side
          x_d     = CX;
          y_d     = CY;
          spd_d   = S_INIT;
          hc_d    = '0;
          scnt_d  = '0;
          state_d = SERVE;
        end
        default: state_d = SERVE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= SERVE;
      tcnt_q  <= '0;
      scnt_q  <= '0;
      x_q     <= CX;
      y_q     <= CY;
      dl_q    <= 1'b0;
      du_q    <= 1'b0;
      spd_q   <= S_INIT;
      hc_q    <= '0;
      sl_q    <= 1'b0;
      sr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      scnt_q  <= scnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dl_q    <= dl_d;
      du_q    <= du_d;
      spd_q   <= spd_d;
      hc_q    <= hc_d;
      sl_q    <= sl_d;
      sr_q    <= sr_d;
    end
  end

  assign ball_pos_x  = x_q;
  assign ball_pos_y  = y_q;
  assign score_left  = sl_q;
  assign score_right = sr_q;
  assign speed       = spd_q;
  assign hit_count   = hc_q;
  assign serving     = (state_q == SERVE);

endmodule

// File: tb/tb_ball_engine.sv
// Bench for ball_engine: vector table, directed rallies and
// randomized play against a rule-level model.
module tb_ball_engine;

  localparam int CX = 316;
  localparam int CY = 236;
  localparam int ST_SERVE = 0;
  localparam int ST_MOVE = 1;
  localparam int ST_SCORED = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pause = 1'b0;
  logic [9:0] lpy_a = '0, rpy_a = '0, lpy_b = '0, rpy_b = '0;
  logic [10:0] xa, ya, xb, yb;
  logic sla, sra, slb, srb, sva, svb;
  logic [2:0] spa, spb;
  logic [7:0] hca, hcb;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ball_engine #(.TICK_DIV(1), .SERVE_DELAY(4)) dut_a (
    .clk(clk), .reset(reset),
    .left_paddle_y(lpy_a), .right_paddle_y(rpy_a),
    .pause(pause),
    .ball_pos_x(xa), .ball_pos_y(ya),
    .score_left(sla), .score_right(sra),
    .speed(spa), .hit_count(hca), .serving(sva)
  );

  ball_engine #(.TICK_DIV(3), .SERVE_DELAY(2)) dut_b (
    .clk(clk), .reset(reset),
    .left_paddle_y(lpy_b), .right_paddle_y(rpy_b),
    .pause(pause),
    .ball_pos_x(xb), .ball_pos_y(yb),
    .score_left(slb), .score_right(srb),
    .speed(spb), .hit_count(hcb), .serving(svb)
  );

  typedef struct {
    int x, y;
    bit left, up;
    int spd, hc, st, scnt, tcnt;
    bit sl, sr;
  } mdl_t;

  typedef struct {
    bit pause;
    int x, y;
    bit serving;
  } vec_t;

  mdl_t ma, mb;
  vec_t vecs[8];

  function automatic mdl_t mdl_init();
    mdl_t m;
    m.x = CX; m.y = CY; m.left = 0; m.up = 0;
    m.spd = 1; m.hc = 0; m.st = ST_SERVE;
    m.scnt = 0; m.tcnt = 0; m.sl = 0; m.sr = 0;
    return m;
  endfunction

  function automatic mdl_t step(mdl_t m, bit p, int lpy,
                                int rpy, int td, int sd);
    mdl_t n;
    int nx, ny;
    bit tk, hit, miss, ol, orr;
    n = m;
    n.sl = 0;
    n.sr = 0;
    if (p) return n;
    tk = (m.tcnt == td - 1);
    n.tcnt = tk ? 0 : m.tcnt + 1;
    if (m.st == ST_SERVE) begin
      if (tk) begin
        n.scnt = m.scnt + 1;
        if (n.scnt >= sd) begin
          n.st = ST_MOVE;
          n.scnt = 0;
        end
      end
    end else if (m.st == ST_SCORED) begin
      n.x = CX; n.y = CY; n.spd = 1; n.hc = 0;
      n.scnt = 0; n.st = ST_SERVE;
    end else if (tk) begin
      nx = m.left ? m.x - m.spd : m.x + m.spd;
      ny = m.up ? m.y - m.spd : m.y + m.spd;
      ol = (m.y + 8 > lpy) && (m.y < lpy + 48);
      orr = (m.y + 8 > rpy) && (m.y < rpy + 48);
      hit = 0;
      miss = 0;
      if (m.left && m.x >= 24 && nx <= 24 && ol) begin
        n.x = 24; n.left = 0; hit = 1;
      end else if (!m.left && m.x + 8 <= 616 &&
                   nx + 8 >= 616 && orr) begin
        n.x = 608; n.left = 1; hit = 1;
      end else if (m.left && nx <= 0) begin
        n.sr = 1; n.st = ST_SCORED; miss = 1;
      end else if (!m.left && nx + 8 >= 640) begin
        n.sl = 1; n.st = ST_SCORED; miss = 1;
      end else begin
        n.x = nx;
      end
      if (!miss) begin
        if (ny <= 0) begin
          n.y = 0; n.up = 0;
        end else if (ny + 8 >= 480) begin
          n.y = 472; n.up = 1;
        end else begin
          n.y = ny;
        end
      end
      if (hit) begin
        n.hc = (m.hc == 255) ? 255 : m.hc + 1;
        if (n.hc % 4 == 0 && m.spd < 4) n.spd = m.spd + 1;
      end
    end
    return n;
  endfunction

  function automatic int track(int y, int off);
    int r;
    r = y - off;
    if (r < 0) r = 0;
    if (r > 432) r = 432;
    return r;
  endfunction

  function automatic int away(int y);
    return (y < 240) ? 400 : 0;
  endfunction

  task automatic check(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic cmp_all();
    check("a_x", xa, ma.x);
    check("a_y", ya, ma.y);
    check("a_score_l", sla, ma.sl);
    check("a_score_r", sra, ma.sr);
    check("a_speed", spa, ma.spd);
    check("a_hits", hca, ma.hc);
    check("a_serving", sva, ma.st == ST_SERVE);
    check("b_x", xb, mb.x);
    check("b_y", yb, mb.y);
    check("b_score_l", slb, mb.sl);
    check("b_score_r", srb, mb.sr);
    check("b_speed", spb, mb.spd);
    check("b_hits", hcb, mb.hc);
    check("b_serving", svb, mb.st == ST_SERVE);
  endtask

  task automatic drive_b();
    lpy_b = 10'(track(mb.y, 19));
    rpy_b = 10'(track(mb.y, 19));
  endtask

  task automatic step_cycle();
    ma = step(ma, pause, lpy_a, rpy_a, 1, 4);
    mb = step(mb, pause, lpy_b, rpy_b, 3, 2);
    @(posedge clk);
    #1;
    cmp_all();
  endtask

  task automatic check_reset_vals(string tag);
    check({tag, "_x"}, xa, CX);
    check({tag, "_y"}, ya, CY);
    check({tag, "_serving"}, sva, 1);
    check({tag, "_speed"}, spa, 1);
    check({tag, "_hits"}, hca, 0);
    check({tag, "_score_l"}, sla, 0);
    check({tag, "_score_r"}, sra, 0);
    check({tag, "_b_x"}, xb, CX);
  endtask

  initial begin
    bit found, seen4, was_l;
    int px, py;

    vecs[0] = '{0, 316, 236, 1};
    vecs[1] = '{0, 316, 236, 1};
    vecs[2] = '{0, 316, 236, 1};
    vecs[3] = '{0, 316, 236, 0};
    vecs[4] = '{0, 317, 237, 0};
    vecs[5] = '{0, 318, 238, 0};
    vecs[6] = '{1, 318, 238, 0};
    vecs[7] = '{0, 319, 239, 0};

    ma = mdl_init();
    mb = mdl_init();
    #2 reset = 1'b0;
    #10;
    check_reset_vals("reset");
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      pause = vecs[i].pause;
      drive_b();
      step_cycle();
      check($sformatf("vec%0d_x", i), xa, vecs[i].x);
      check($sformatf("vec%0d_y", i), ya, vecs[i].y);
      check($sformatf("vec%0d_serving", i), sva, vecs[i].serving);
    end
    pause = 1'b0;

    found = 0;
    for (int i = 0; i < 1000; i++) begin
      if (ma.st == ST_MOVE && !ma.left && ma.x == 607) begin
        rpy_a = 10'(track(ma.y, 19));
        drive_b();
        step_cycle();
        check("rhit_x", xa, 608);
        check("rhit_count", hca, 1);
        check("rhit_no_score", sla | sra, 0);
        rpy_a = '0;
        drive_b();
        step_cycle();
        check("rhit_bounce_left", xa, 607);
        found = 1;
        break;
      end
      rpy_a = '0;
      drive_b();
      step_cycle();
    end
    check("rhit_reached", found, 1);

    found = 0;
    seen4 = 0;
    for (int i = 0; i < 20000; i++) begin
      lpy_a = 10'(track(ma.y, 19));
      rpy_a = 10'(track(ma.y, 19));
      drive_b();
      step_cycle();
      if (!seen4 && ma.hc == 4) begin
        check("speed_after_4", spa, 2);
        seen4 = 1;
      end
      if (ma.hc == 16) begin
        check("speed_saturated", spa, 4);
        check("hits_16", hca, 16);
        found = 1;
        break;
      end
    end
    check("speedup_reached", found, 1);

    found = 0;
    was_l = 0;
    for (int i = 0; i < 5000; i++) begin
      lpy_a = 10'(away(ma.y));
      rpy_a = 10'(away(ma.y));
      drive_b();
      step_cycle();
      if (ma.sl || ma.sr) begin
        was_l = ma.sl;
        check("miss_pulse", sla | sra, 1);
        found = 1;
        break;
      end
    end
    check("miss_reached", found, 1);
    drive_b();
    step_cycle();
    check("pulse_one_clk", sla | sra, 0);
    check("scored_x", xa, CX);
    check("scored_y", ya, CY);
    check("scored_serving", sva, 1);
    check("scored_speed", spa, 1);
    check("scored_hits", hca, 0);
    for (int i = 0; i < 4; i++) begin
      drive_b();
      step_cycle();
    end
    drive_b();
    step_cycle();
    check("serve_dir", xa, was_l ? CX + 1 : CX - 1);

    for (int i = 0; i < 20; i++) begin
      lpy_a = 10'(away(ma.y));
      rpy_a = 10'(away(ma.y));
      drive_b();
      step_cycle();
    end
    pause = 1'b1;
    px = ma.x;
    py = ma.y;
    for (int i = 0; i < 10; i++) begin
      drive_b();
      step_cycle();
    end
    check("pause_x", xa, px);
    check("pause_y", ya, py);
    pause = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_b();
      step_cycle();
    end

    #2 reset = 1'b0;
    #1;
    check_reset_vals("async");
    ma = mdl_init();
    mb = mdl_init();
    @(posedge clk);
    #1;
    check_reset_vals("held");
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      pause = ($urandom_range(0, 15) == 0);
      lpy_a = ($urandom_range(0, 3) != 0) ?
        10'(track(ma.y, $urandom_range(0, 40))) :
        10'($urandom_range(0, 432));
      rpy_a = ($urandom_range(0, 3) != 0) ?
        10'(track(ma.y, $urandom_range(0, 40))) :
        10'($urandom_range(0, 432));
      lpy_b = ($urandom_range(0, 3) != 0) ?
        10'(track(mb.y, $urandom_range(0, 40))) :
        10'($urandom_range(0, 432));
      rpy_b = ($urandom_range(0, 3) != 0) ?
        10'(track(mb.y, $urandom_range(0, 40))) :
        10'($urandom_range(0, 432));
      step_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
